// File: rtl/trace_display_if.sv
// Bundles the capture inputs and the display/status outputs of trace_display.
// The bench drives through the master modport; the design uses the slave modport.
interface trace_display_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int NDIG = 2 * DATA_W / 4;
    localparam int CW   = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] PCIn;
    logic [DATA_W-1:0] InstrIn;
    logic              InValid;
    logic              Freeze;
    logic              Step;
    logic [6:0]        out7;
    logic [NDIG-1:0]   en_out;
    logic [CW-1:0]     Count;
    logic              Frozen;

    modport master (
        output PCIn, InstrIn, InValid, Freeze, Step,
        input  out7, en_out, Count, Frozen
    );

    modport slave (
        input  PCIn, InstrIn, InValid, Freeze, Step,
        output out7, en_out, Count, Frozen
    );
endinterface

// File: rtl/trace_display.sv
// Circular PC/instruction trace buffer with live/frozen viewing, shown on a
// multiplexed active-low 7-segment display (PC on the low digits, instruction above).
module trace_display #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic           Clk,
    input  logic           Reset,
    trace_display_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int NDIG = 2 * DATA_W / 4;
    localparam int DGW  = $clog2(NDIG);
    localparam int SW   = $clog2(SCAN_DIV);

    typedef enum logic {LIVE, FROZEN} state_t;

    state_t            state_q;
    logic [AW-1:0]     wrPtr_q;
    logic [AW-1:0]     offset_q;
    logic [AW:0]       count_q;
    logic [DATA_W-1:0] pcMem_q    [DEPTH];
    logic [DATA_W-1:0] instrMem_q [DEPTH];
    logic [SW-1:0]     scanCnt_q;
    logic [DGW-1:0]    digit_q;

    logic                doWrite;
    logic                doStep;
    logic [AW-1:0]       rdIdx;
    logic [2*DATA_W-1:0] viewWord;
    logic [3:0]          nibble;
    logic [NDIG-1:0]     enable;

    // The entering cycle is still LIVE, so a capture there lands in the frozen view.
    assign doWrite = (state_q == LIVE) && bus.InValid;
    assign doStep  = (state_q == FROZEN) && bus.Step && (count_q != '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= LIVE;
            wrPtr_q  <= '0;
            count_q  <= '0;
            offset_q <= '0;
        end else begin
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + AW'(1);
                if (count_q != (AW+1)'(DEPTH))
                    count_q <= count_q + (AW+1)'(1);
            end
            case (state_q)
                LIVE: begin
                    if (bus.Freeze) begin
                        state_q  <= FROZEN;
                        offset_q <= '0;
                    end
                end
                FROZEN: begin
                    if (!bus.Freeze)
                        state_q <= LIVE;
                    else if (doStep)
                        offset_q <= ({1'b0, offset_q} == count_q - (AW+1)'(1)) ? '0 : offset_q + AW'(1);
                end
                default: state_q <= LIVE;
            endcase
        end
    end

    // Buffer storage is never cleared; Count gates every read of it.
    always_ff @(posedge Clk) begin
        if (doWrite) begin
            pcMem_q[wrPtr_q]    <= bus.PCIn;
            instrMem_q[wrPtr_q] <= bus.InstrIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scanCnt_q <= '0;
            digit_q   <= '0;
        end else if (scanCnt_q == SW'(SCAN_DIV - 1)) begin
            scanCnt_q <= '0;
            digit_q   <= (digit_q == DGW'(NDIG - 1)) ? '0 : digit_q + DGW'(1);
        end else begin
            scanCnt_q <= scanCnt_q + SW'(1);
        end
    end

    assign rdIdx    = wrPtr_q - AW'(1) - ((state_q == FROZEN) ? offset_q : '0);
    assign viewWord = (count_q == '0) ? '0 : {instrMem_q[rdIdx], pcMem_q[rdIdx]};

    always_comb begin
        nibble = '0;
        enable = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_q == DGW'(i)) begin
                nibble    = viewWord[4*i +: 4];
                enable[i] = 1'b0;
            end
        end
    end

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: hexSeg = 7'b1000000;
            4'h1: hexSeg = 7'b1111001;
            4'h2: hexSeg = 7'b0100100;
            4'h3: hexSeg = 7'b0110000;
            4'h4: hexSeg = 7'b0011001;
            4'h5: hexSeg = 7'b0010010;
            4'h6: hexSeg = 7'b0000010;
            4'h7: hexSeg = 7'b1111000;
            4'h8: hexSeg = 7'b0000000;
            4'h9: hexSeg = 7'b0010000;
            4'hA: hexSeg = 7'b0001000;
            4'hB: hexSeg = 7'b0000011;
            4'hC: hexSeg = 7'b1000110;
            4'hD: hexSeg = 7'b0100001;
            4'hE: hexSeg = 7'b0000110;
            default: hexSeg = 7'b0001110;
        endcase
    endfunction

    assign bus.out7   = hexSeg(nibble);
    assign bus.en_out = enable;
    assign bus.Count  = count_q;
    assign bus.Frozen = (state_q == FROZEN);
endmodule
